// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
//   Shares one BRAM port between requester 0 (AXI BRAM controller) and
//   requester 1 (fabric test engine). Round-robin grant with a per-grant
//   burst limit, registered grants, combinational mux onto the BRAM port,
//   and a tag pipeline matching the BRAM read latency so read data is
//   strobed back to whoever issued the read.
//
// Ports
//   axi_aclk, axi_aresetn        clock, async active-low reset
//   reqN / gntN                  request / registered grant per requester
//   enN, weN, addrN, dinN        access from requester N (en honoured with gnt)
//   doutN, rvalidN               read return to requester N
//   bram_en/we/addr/din, bram_dout   BRAM port
//   viol                         sticky: en seen without a grant
module bram_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16
) (
  input  logic                axi_aclk,
  input  logic                axi_aresetn,
  input  logic                req0,
  input  logic                req1,
  output logic                gnt0,
  output logic                gnt1,
  input  logic                en0,
  input  logic                en1,
  input  logic [DATA_W/8-1:0] we0,
  input  logic [DATA_W/8-1:0] we1,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [DATA_W-1:0]   din0,
  input  logic [DATA_W-1:0]   din1,
  output logic [DATA_W-1:0]   dout0,
  output logic [DATA_W-1:0]   dout1,
  output logic                rvalid0,
  output logic                rvalid1,
  output logic                bram_en,
  output logic [DATA_W/8-1:0] bram_we,
  output logic [ADDR_W-1:0]   bram_addr,
  output logic [DATA_W-1:0]   bram_din,
  input  logic [DATA_W-1:0]   bram_dout,
  output logic                viol
);

  localparam int NB    = DATA_W / 8;
  // one extra headroom value so beat_cnt+1 never wraps at saturation
  localparam int CNT_W = $clog2(MAX_BURST + 2);
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  typedef struct packed {
    logic              en;
    logic [NB-1:0]     we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
  } port_req_t;

  port_req_t [1:0]  rq;
  port_req_t        own_rq;
  logic [1:0]       req_v;

  state_t           state, state_nxt, state_oth;
  logic             owner;       // index of current owner (valid in OWN0/OWN1)
  logic             last_owner;
  logic             own_req, oth_req;
  logic             acc;         // owner's en accepted this cycle
  logic             rd_issue;
  logic [CNT_W-1:0] beat_cnt, beat_inc;

  logic [RD_LAT-1:0] vld_pipe;
  logic [RD_LAT-1:0] own_pipe;

  assign rq[0] = {en0, we0, addr0, din0};
  assign rq[1] = {en1, we1, addr1, din1};
  assign req_v = {req1, req0};

  assign owner     = (state == OWN1);
  assign own_req   = req_v[owner];
  assign oth_req   = req_v[~owner];
  assign state_oth = owner ? OWN0 : OWN1;
  assign beat_inc  = beat_cnt + CNT_W'(1);

  // ---------------- state register ----------------
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state      <= IDLE;
      last_owner <= 1'b1;   // requester 0 wins the first tie
      beat_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == OWN0 && state != OWN0) last_owner <= 1'b0;
      if (state_nxt == OWN1 && state != OWN1) last_owner <= 1'b1;
      // counter restarts with each grant; saturates so an uncontested
      // owner simply keeps the port
      if (state_nxt != state)                 beat_cnt <= '0;
      else if (acc && beat_cnt < BURST_LIM)   beat_cnt <= beat_inc;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && req1)  state_nxt = last_owner ? OWN0 : OWN1;
        else if (req0)     state_nxt = OWN0;
        else if (req1)     state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        if (!own_req)
          state_nxt = oth_req ? state_oth : IDLE;
        else if (oth_req && acc && beat_inc >= BURST_LIM)
          state_nxt = state_oth;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- outputs / BRAM mux ----------------
  always_comb begin
    gnt0      = (state == OWN0);
    gnt1      = (state == OWN1);
    own_rq    = rq[owner];
    bram_en   = own_rq.en & (state != IDLE);
    bram_we   = bram_en ? own_rq.we : '0;
    bram_addr = own_rq.addr;
    bram_din  = own_rq.din;
    acc       = bram_en;
    rd_issue  = bram_en & (own_rq.we == '0);
  end

  // ---------------- read tag pipeline ----------------
  // Each slot carries {valid, issuer}; the issuer travels with the read so
  // data lands at the right requester even if the grant moved meanwhile.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      vld_pipe <= '0;
      own_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_issue;
      own_pipe[0] <= owner;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        own_pipe[i] <= own_pipe[i-1];
      end
    end
  end

  assign rvalid0 = vld_pipe[RD_LAT-1] & ~own_pipe[RD_LAT-1];
  assign rvalid1 = vld_pipe[RD_LAT-1] &  own_pipe[RD_LAT-1];
  assign dout0   = bram_dout;
  assign dout1   = bram_dout;

  // ---------------- protocol violation ----------------
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn)                          viol <= 1'b0;
    else if ((en0 && !gnt0) || (en1 && !gnt1)) viol <= 1'b1;
  end

endmodule
